maple_line_decoder: RTL

- Maple bus line-level receiver: samples the two bus lines, detects the start pattern, recovers bits, emits one byte per write pulse, and detects the end pattern.
- Sits directly upstream of the bus-to-host FIFO bridge and feeds it rx bytes.
- Its sdcka/sdckb inputs are already forced high by the top level while the transmitter drives the bus.

---
 rtl/maple_line_decoder.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/maple_line_decoder.sv
// Maple bus line-level receiver.
// Synchronises sdcka/sdckb, detects line edges, recognises the start pattern,
// recovers bits MSB first into bytes and recognises the end pattern.
// Optional build macro MAPLE_RX_CHECKSUM_EN: the XOR of all bytes in a frame
// must be zero, and the frame must contain at least one byte, for the end
// pattern to report frame_done; otherwise frame_err is pulsed instead.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus idle, waiting for A to fall while B is high
// START    | A held low, counting B falls of the start pattern
// DATA_A   | next bit is clocked by an A fall, data on B
// DATA_B   | next bit is clocked by a B fall, data on A
// END_CHK  | leading 0 seen on A fall: either a 0 data bit or an end pattern
// END_WAIT | end pattern seen, waiting for B to rise

module maple_line_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sdcka,
    input  logic       sdckb,
    output logic       busy,
    output logic       write,
    output logic [7:0] data,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE, START, DATA_A, DATA_B, END_CHK, END_WAIT
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   a_q, b_q;
    logic                   a_s, b_s;
    logic                   a_fall, a_rise, b_fall, b_rise, any_evt;

    state_t           state_q, state_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_d;
    logic [7:0]       b_byte;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             write_d, done_d, err_d;
`ifdef MAPLE_RX_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic             got_q, got_d;
`endif

    // Input synchronisers preset to the idle-high level, plus one edge-detect stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '1;
            sync_b <= '1;
            a_q    <= 1'b1;
            b_q    <= 1'b1;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], sdcka};
            sync_b <= {sync_b[SYNC_STAGES-2:0], sdckb};
            a_q    <= sync_a[SYNC_STAGES-1];
            b_q    <= sync_b[SYNC_STAGES-1];
        end
    end

    assign a_s     = sync_a[SYNC_STAGES-1];
    assign b_s     = sync_b[SYNC_STAGES-1];
    assign a_fall  = a_q & ~a_s;
    assign a_rise  = ~a_q & a_s;
    assign b_fall  = b_q & ~b_s;
    assign b_rise  = ~b_q & b_s;
    assign any_evt = a_fall | a_rise | b_fall | b_rise;
    assign b_byte  = {shreg_q[6:0], a_s};
    assign busy    = (state_q != IDLE);

    // State, datapath and registered output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            tmr_q      <= TMR_LOAD;
            data       <= '0;
            write      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
`ifdef MAPLE_RX_CHECKSUM_EN
            csum_q     <= '0;
            got_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            tmr_q      <= tmr_d;
            data       <= data_d;
            write      <= write_d;
            frame_done <= done_d;
            frame_err  <= err_d;
`ifdef MAPLE_RX_CHECKSUM_EN
            csum_q     <= csum_d;
            got_q      <= got_d;
`endif
        end
    end

    // Next-state logic; aborts (simultaneous falls, timeout) take priority over bit handling.
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data;
        write_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (any_evt || state_q == IDLE)
            tmr_d = TMR_LOAD;
        else if (tmr_q != '0)
            tmr_d = tmr_q - TMR_W'(1);
        else
            tmr_d = tmr_q;
`ifdef MAPLE_RX_CHECKSUM_EN
        csum_d = csum_q;
        got_d  = got_q;
`endif

        if (a_fall && b_fall) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else if (state_q != IDLE && !any_evt && tmr_q == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_fall && b_s) begin
                        state_d = START;
                        bcnt_d  = '0;
`ifdef MAPLE_RX_CHECKSUM_EN
                        csum_d  = '0;
                        got_d   = 1'b0;
`endif
                    end
                end
                START: begin
                    if (b_fall && bcnt_q != 3'd7)
                        bcnt_d = bcnt_q + 3'd1;
                    if (a_rise) begin
                        if (bcnt_q == 3'd4) begin
                            state_d  = DATA_A;
                            bitcnt_d = '0;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                DATA_A: begin
                    if (a_fall) begin
                        shreg_d  = {shreg_q[6:0], b_s};
                        bitcnt_d = bitcnt_q + 3'd1;
                        state_d  = (bitcnt_q == 3'd0 && !b_s) ? END_CHK : DATA_B;
                    end
                end
                DATA_B, END_CHK: begin
                    if (b_fall) begin
                        shreg_d  = b_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        state_d  = DATA_A;
                        if (bitcnt_q == 3'd7) begin
                            data_d  = b_byte;
                            write_d = 1'b1;
`ifdef MAPLE_RX_CHECKSUM_EN
                            csum_d  = csum_q ^ b_byte;
                            got_d   = 1'b1;
`endif
                        end
                    end else if (state_q == END_CHK && a_fall && !b_s) begin
                        // End pattern: the tentative leading 0 was not data.
                        bitcnt_d = '0;
                        state_d  = END_WAIT;
                    end
                end
                END_WAIT: begin
                    if (b_rise) begin
                        state_d = IDLE;
`ifdef MAPLE_RX_CHECKSUM_EN
                        if (csum_q != 8'h00 || !got_q)
                            err_d = 1'b1;
                        else
                            done_d = 1'b1;
`else
                        done_d = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
